hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Drives the hold/bubble/flush controls of the IF, IF_ID, ID_EX and EX_MEM stages.
//  Detects load-use hazards between ID and EX and inserts one bubble into ID_EX.
//  Freezes the whole pipe while data memory is busy, with a wait watchdog.
//  Flushes IF_ID on a taken branch/jump, and counts stall cycles for debug.
// PARAMETERS
//  MAX_WAIT  16  maximum consecutive mem_ready-low cycles before FAULT (>=1)
//  CNT_W     16  width of stall_count perf counter
// PORTS
//  clk           in   1      pipeline clock, rising edge
//  reset         in   1      synchronous, active-high
//  id_rs         in   5      rs of instruction in ID (inst[25:21])
//  id_rt         in   5      rt of instruction in ID (inst[20:16])
//  id_uses_rt    in   1      ID instruction reads rt as a source (R-type, store, beq)
//  ex_memread    in   1      MemRead bit of ID_EX control word
//  ex_rt         in   5      ID_EX inst[20:16] (load destination)
//  mem_access    in   1      EX_MEM MemRead|MemWrite
//  mem_ready     in   1      data memory completes the access this cycle
//  branch_taken  in   1      EX resolved a taken branch/jump this cycle
//  pc_hold       out  1      PC keeps its value
//  ifid_hold     out  1      IF_ID keeps its value
//  ifid_flush    out  1      IF_ID loads a NOP
//  idex_hold     out  1      ID_EX holdreg
//  idex_bubble   out  1      zeroes the 10-bit control word muxed into ID_EX
//  exmem_hold    out  1      EX_MEM keeps its value
//  stall_count   out  CNT_W  saturating count of cycles with pc_hold=1
//  mem_timeout   out  1      sticky watchdog error
// BEHAVIOUR
//  Hold/bubble/flush outputs are combinational from inputs and state (same-cycle effect).
//  stall_count, mem_timeout and the FSM are registered.
//  load_use = ex_memread & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
//  mem_stall = mem_access & ~mem_ready.
//  FSM states: RUN, MEM_WAIT, FAULT. Reset -> RUN, wait_cnt=0.
//   RUN: mem_stall -> MEM_WAIT, wait_cnt=1; otherwise stay.
//   MEM_WAIT: mem_ready -> RUN, wait_cnt=0.
//    Otherwise wait_cnt+1; reaching MAX_WAIT -> FAULT and set mem_timeout.
//   FAULT: absorbing until reset.
//  Output priority, highest first:
//   1 FAULT, or RUN/MEM_WAIT with mem_stall:
//     pc_hold, ifid_hold, idex_hold and exmem_hold = 1. bubble=0, flush=0.
//     branch_taken and load_use are ignored; they are re-evaluated once the freeze ends.
//   2 branch_taken: ifid_flush=1, idex_bubble=1, holds=0.
//     The ID instruction is squashed, so load_use is ignored.
//   3 load_use: pc_hold=1, ifid_hold=1, idex_bubble=1, idex_hold=0, exmem_hold=0.
//     Exactly one bubble, because the next cycle ex_memread=0.
//   4 otherwise: all outputs 0.
//  The cycle that sees mem_ready=1 in MEM_WAIT is not frozen; the pipe advances that edge.
//  stall_count increments on each edge where pc_hold=1 and saturates at all-ones.
//  Reset values: stall_count=0, mem_timeout=0, state RUN, so all holds/flush/bubble are 0
//   unless the inputs assert mem_stall, branch_taken or load_use combinationally.
//  Reset asserted mid-wait or in FAULT returns to RUN on the same edge.
//   This clears mem_timeout and stall_count.
//  Register $0 never creates a load-use hazard.
// STRUCTURE
//  Shared package/header: FSM state encodings; control-word bit indices (MemRead, MemWrite, RegWrite).
//  Sub-module hazard_detect: purely combinational load_use compare.
//  The FSM, watchdog and counters stay in this module.
// TESTING
//  1 lw $5 in EX, add $7,$5,$2 in ID -> pc_hold, ifid_hold and idex_bubble =1 for exactly 1 cycle.
//    stall_count=1.
//  2 lw $0 in EX, ID reads $0; or ID rt=$5 with id_uses_rt=0 -> no hold, no bubble.
//  3 mem_access=1 with mem_ready low 3 cycles then high -> all holds =1 for 3 cycles.
//    Release on the 4th cycle; stall_count=3, state back to RUN.
//  4 MAX_WAIT=4, mem_ready stuck 0 -> FAULT after 4 cycles, mem_timeout=1, holds stay 1.
//    A reset pulse clears everything.
//  5 branch_taken=1 with load_use=1 -> ifid_flush=1, idex_bubble=1, pc_hold=0.
//    The same case under mem_stall -> freeze only, flush=0.
//  6 Force stall_count to all-ones minus 1, then 3 stall cycles -> saturates at all-ones, no wrap.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: FSM state
// encodings, register-index type and ID_EX control-word bit positions.
package hazard_stall_ctrl_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  // Controller FSM encodings (kept as plain constants for legacy tools)
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_FAULT    = 2'd2;

  // Layout of the 10-bit ID_EX control word that idex_bubble zeroes
  localparam int CW_W        = 10;
  localparam int CW_REGWRITE = 0;
  localparam int CW_MEMREAD  = 3;
  localparam int CW_MEMWRITE = 4;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard/stall
// controller (slave): hazard sources in, hold/bubble/flush controls out.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  import hazard_stall_ctrl_pkg::*;

  reg_idx_t         id_rs;
  reg_idx_t         id_rt;
  logic             id_uses_rt;
  logic             ex_memread;
  reg_idx_t         ex_rt;
  logic             mem_access;
  logic             mem_ready;
  logic             branch_taken;
  logic             pc_hold;
  logic             ifid_hold;
  logic             ifid_flush;
  logic             idex_hold;
  logic             idex_bubble;
  logic             exmem_hold;
  logic [CNT_W-1:0] stall_count;
  logic             mem_timeout;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
           mem_access, mem_ready, branch_taken,
    input  pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble,
           exmem_hold, stall_count, mem_timeout
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
           mem_access, mem_ready, branch_taken,
    output pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble,
           exmem_hold, stall_count, mem_timeout
  );

endinterface

// File: rtl/hazard_stall_ctrl_hazard_detect.sv
// Combinational load-use compare between the load in EX and the
// instruction in ID. Register $0 is hardwired and never hazards.
module hazard_detect
  import hazard_stall_ctrl_pkg::*;
(
  input  reg_idx_t id_rs,
  input  reg_idx_t id_rt,
  input  logic     id_uses_rt,
  input  logic     ex_memread,
  input  reg_idx_t ex_rt,
  output logic     load_use
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ex_rt == id_rs);
  assign rt_match = id_uses_rt & (ex_rt == id_rt);
  assign load_use = ex_memread & (ex_rt != REG_ZERO) & (rs_match | rt_match);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hold/bubble/flush controller: load-use bubble insertion,
// whole-pipe freeze on data-memory wait with watchdog, branch flush and a
// saturating stall-cycle counter.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  hazard_stall_ctrl_if.slave  bus
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

  logic [1:0]        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_inc;
  logic [CNT_W-1:0]  stall_count;
  logic              mem_timeout;
  logic              load_use;
  logic              mem_stall;
  logic              freeze;

  hazard_detect u_hazard_detect (
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .id_uses_rt (bus.id_uses_rt),
    .ex_memread (bus.ex_memread),
    .ex_rt      (bus.ex_rt),
    .load_use   (load_use)
  );

  assign mem_stall = bus.mem_access & ~bus.mem_ready;
  // FAULT freezes unconditionally; otherwise only an outstanding access does
  assign freeze    = (state == ST_FAULT) | mem_stall;
  assign wait_inc  = wait_cnt + WAIT_ONE;

  // Prioritised same-cycle controls: freeze > branch flush > load-use bubble
  always_comb begin
    bus.pc_hold     = 1'b0;
    bus.ifid_hold   = 1'b0;
    bus.ifid_flush  = 1'b0;
    bus.idex_hold   = 1'b0;
    bus.idex_bubble = 1'b0;
    bus.exmem_hold  = 1'b0;
    if (freeze) begin
      bus.pc_hold    = 1'b1;
      bus.ifid_hold  = 1'b1;
      bus.idex_hold  = 1'b1;
      bus.exmem_hold = 1'b1;
    end else if (bus.branch_taken) begin
      bus.ifid_flush  = 1'b1;
      bus.idex_bubble = 1'b1;
    end else if (load_use) begin
      bus.pc_hold     = 1'b1;
      bus.ifid_hold   = 1'b1;
      bus.idex_bubble = 1'b1;
    end
  end

  // Memory-wait FSM with consecutive-wait watchdog; FAULT is sticky until reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_stall) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= WAIT_ONE;
          end
        end
        ST_MEM_WAIT: begin
          if (bus.mem_ready) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_inc >= WAIT_LIMIT) begin
            state       <= ST_FAULT;
            wait_cnt    <= wait_inc;
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_inc;
          end
        end
        ST_FAULT: begin
          state <= ST_FAULT;
        end
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Debug counter of PC-hold cycles, saturating at all-ones
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (bus.pc_hold && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  assign bus.stall_count = stall_count;
  assign bus.mem_timeout = mem_timeout;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios followed by random
// traffic, every cycle compared against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic clk;
  logic reset;

  int n_checks;
  int n_fail;

  // Behavioural model state
  bit m_fault;
  bit m_waiting;
  int m_low_cycles;
  int m_stalls;
  bit m_timeout;

  // Last observed DUT values (sampled mid-cycle)
  int o_pc_hold;
  int o_stall_count;
  int o_mem_timeout;

  hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_stall_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, compare against the model, then advance a clock edge
  task automatic cycle(input int rs, input int rt, input bit uses, input bit mrd,
                       input int exrt, input bit macc, input bit rdy, input bit bt,
                       input bit rst);
    bit lu, ms, e_pc, e_ifh, e_fl, e_idh, e_bub, e_exh;
    @(negedge clk);
    reset            = rst;
    bus.id_rs        = 5'(rs);
    bus.id_rt        = 5'(rt);
    bus.id_uses_rt   = uses;
    bus.ex_memread   = mrd;
    bus.ex_rt        = 5'(exrt);
    bus.mem_access   = macc;
    bus.mem_ready    = rdy;
    bus.branch_taken = bt;
    #1;
    lu = mrd && (exrt != 0) && ((exrt == rs) || (uses && (exrt == rt)));
    ms = macc && !rdy;
    {e_pc, e_ifh, e_fl, e_idh, e_bub, e_exh} = '0;
    if (m_fault || ms) begin
      e_pc = 1; e_ifh = 1; e_idh = 1; e_exh = 1;
    end else if (bt) begin
      e_fl = 1; e_bub = 1;
    end else if (lu) begin
      e_pc = 1; e_ifh = 1; e_bub = 1;
    end
    check("pc_hold",     int'(bus.pc_hold),     int'(e_pc));
    check("ifid_hold",   int'(bus.ifid_hold),   int'(e_ifh));
    check("ifid_flush",  int'(bus.ifid_flush),  int'(e_fl));
    check("idex_hold",   int'(bus.idex_hold),   int'(e_idh));
    check("idex_bubble", int'(bus.idex_bubble), int'(e_bub));
    check("exmem_hold",  int'(bus.exmem_hold),  int'(e_exh));
    check("stall_count", int'(bus.stall_count), m_stalls);
    check("mem_timeout", int'(bus.mem_timeout), int'(m_timeout));
    o_pc_hold     = int'(bus.pc_hold);
    o_stall_count = int'(bus.stall_count);
    o_mem_timeout = int'(bus.mem_timeout);
    // Model update for the coming edge
    if (rst) begin
      m_fault = 0; m_waiting = 0; m_low_cycles = 0; m_stalls = 0; m_timeout = 0;
    end else begin
      if (e_pc && m_stalls < CNT_MAX) m_stalls++;
      if (!m_fault) begin
        if (!m_waiting) begin
          if (ms) begin
            m_waiting = 1;
            m_low_cycles = 1;
          end
        end else if (rdy) begin
          m_waiting = 0;
          m_low_cycles = 0;
        end else begin
          m_low_cycles++;
          if (m_low_cycles >= MAX_WAIT) begin
            m_fault = 1;
            m_waiting = 0;
            m_timeout = 1;
          end
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input bit rst);
    cycle(0, 0, 0, 0, 0, 0, 1, 0, rst);
  endtask

  initial begin
    int rs, rt, exrt;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 0; bus.ex_memread = 0;
    bus.ex_rt = '0; bus.mem_access = 0; bus.mem_ready = 1; bus.branch_taken = 0;
    repeat (2) @(posedge clk);
    m_fault = 0; m_waiting = 0; m_low_cycles = 0; m_stalls = 0; m_timeout = 0;

    // Reset state
    idle(1);
    idle(0);
    check("reset_stall_count", o_stall_count, 0);

    // Load-use: lw $5 in EX, add $7,$5,$2 in ID -> one bubble
    cycle(5, 2, 1, 1, 5, 0, 1, 0, 0);
    check("lu_pc_hold", o_pc_hold, 1);
    cycle(5, 2, 1, 0, 7, 0, 1, 0, 0);
    check("lu_one_bubble", o_pc_hold, 0);
    check("lu_stall_count", o_stall_count, 1);

    // $0 destination, and rt match without rt use -> no hazard
    cycle(0, 0, 1, 1, 0, 0, 1, 0, 0);
    check("zero_reg_no_hold", o_pc_hold, 0);
    cycle(3, 5, 0, 1, 5, 0, 1, 0, 0);
    check("rt_unused_no_hold", o_pc_hold, 0);

    // Memory wait 3 cycles then release
    idle(1);
    repeat (3) cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 1, 0, 0);
    check("mem_release", o_pc_hold, 0);
    idle(0);
    check("mem_stall_count", o_stall_count, 3);

    // Watchdog: mem_ready stuck low -> FAULT, then reset pulse clears it
    idle(1);
    repeat (MAX_WAIT) cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(0);
    check("fault_timeout", o_mem_timeout, 1);
    check("fault_hold", o_pc_hold, 1);
    idle(1);
    idle(0);
    check("fault_cleared", o_mem_timeout, 0);
    check("fault_cnt_cleared", o_stall_count, 0);

    // Branch beats load-use; freeze beats branch
    cycle(4, 4, 1, 1, 4, 0, 1, 1, 0);
    check("br_pc_hold", o_pc_hold, 0);
    cycle(4, 4, 1, 1, 4, 1, 0, 1, 0);
    cycle(4, 4, 1, 1, 4, 1, 1, 1, 0);

    // Saturation of stall_count
    idle(1);
    repeat (CNT_MAX - 1) cycle(6, 0, 0, 1, 6, 0, 1, 0, 0);
    idle(0);
    check("sat_pre", o_stall_count, CNT_MAX - 1);
    repeat (3) cycle(6, 0, 0, 1, 6, 0, 1, 0, 0);
    idle(0);
    check("sat_final", o_stall_count, CNT_MAX);

    // Random traffic against the model
    idle(1);
    for (int i = 0; i < 3000; i++) begin
      rs   = $urandom_range(0, 3);
      rt   = $urandom_range(0, 3);
      exrt = $urandom_range(0, 3);
      cycle(rs, rt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), exrt,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 39) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
